pwm_dac: RTL and testbench
==========================

Name: pwm_dac

Overview:
- Output stage directly downstream of the amplitude multiplier (`Mult`) in the DDS chain.
- Takes the unsigned 2M-bit product and keeps its top RES bits as a duty value.
- Drives a single-pin PWM output for off-chip RC filtering.
- Latches a new duty only at PWM period boundaries and strobes `sample_req` so upstream can pace itself to the output rate.

Parameters:
- M, 8, operand width of the upstream multiplier; product input is 2M bits.
- RES, 8, PWM resolution in bits; period = 2^RES clocks; legal range 1 ≤ RES ≤ 2M.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mult  input  2M  unsigned product from `Mult`.
- mult_valid  input  1  `mult` holds a new sample this cycle.
- enable  input  1  run request.
- pwm_out  output  1  registered PWM waveform.
- sample_req  output  1  one-cycle pulse when the duty register is reloaded.
- overrun  output  1  sticky: a pending sample was overwritten before it was consumed.
- busy  output  1  high in RUN or DRAIN.

Behaviour:
- Reset (async, rst_n=0) clears: state=IDLE, cnt=0, pending=0, pend_full=0, duty=0, pwm_out=0, sample_req=0, overrun=0, busy=0. Reset mid-period aborts immediately; the output goes low with no glitch-free guarantee.
- Pending register:
  - On mult_valid, pending ← mult[2M-1 -: RES] and pend_full ← 1.
  - If pend_full is already 1 and no boundary load happens that cycle, overrun ← 1.
- Period boundary: the cycle with cnt = 2^RES−1 in RUN/DRAIN, plus the IDLE→RUN entry cycle.
- Load rule at a boundary:
  - duty ← pending, pend_full ← 0, sample_req=1 for that cycle.
  - If mult_valid is asserted in the same cycle, the new value bypasses straight into duty and pend_full stays 0.
  - If pend_full=0 and there is no mult_valid, duty holds its previous value and sample_req still pulses.
- Counter: cnt increments by 1 each cycle in RUN/DRAIN, wrapping from 2^RES−1 to 0; it is held at 0 in IDLE.
- Output: pwm_out(t+1) = (cnt(t) < duty(t)) in RUN/DRAIN, and 0 in IDLE.
  - duty=0 gives a constant low output.
  - duty=2^RES−1 gives a high output for 2^RES−1 of every 2^RES cycles.
  - Latency from a duty load to its first effect on pwm_out is 1 clock.
- State machine:
  - IDLE→RUN when enable=1; that cycle performs a boundary load, clears overrun, and sets cnt=0.
  - RUN→DRAIN when enable=0 mid-period.
  - RUN→IDLE directly when enable=0 on a boundary cycle.
  - DRAIN→IDLE at the next boundary cycle, with no load and no sample_req.
  - DRAIN→RUN when enable returns to 1 before the boundary; counting continues uninterrupted.
- busy = (state ≠ IDLE).
- overrun is cleared only by reset or the IDLE→RUN transition.

Optional Feature:
- Macro: PWM_DAC_ROUND_EN.
- Defined:
  - pending ← round-half-up of the top RES bits, i.e. mult[2M-1 -: RES] + mult[2M-RES-1].
  - The result saturates at 2^RES−1.
  - When RES=2M there is no rounding bit; the value is plain truncation.
- Undefined: plain truncation, with no extra adder in the datapath.

Decomposition:
- Shared package `dds_pkg`:
  - state enum {IDLE, RUN, DRAIN};
  - default M/RES localparams;
  - function `quantize(mult)` implementing truncation or rounding.
- One natural sub-module, `pwm_cnt`: the RES-bit counter with a wrap/boundary flag and the compare-and-register output. The FSM and pending/duty handshake stay in the top module.

Test Plan:
- Truncation: rst_n low→high, enable=1, mult=16'h70E4 (0xAA×0xAA) pulsed with mult_valid before the first wrap → after the next boundary, pwm_out high exactly 112 of 256 cycles per period; sample_req pulses every 256 clocks.
- Rounding: same stimulus with PWM_DAC_ROUND_EN → 113 high cycles per period. mult=16'hFFFF → duty saturates at 255 (255 high, 1 low).
- Boundary bypass: mult_valid with mult=16'h8000 in the exact cycle cnt=255 → duty=128 from the next period; pend_full=0; overrun stays 0.
- Overrun: two mult_valid pulses (16'h1000, then 16'h2000) within one period → overrun=1 and the next period duty=0x20. Toggling enable 0→1 through IDLE clears overrun.
- Drain: drop enable at cnt=100 with duty=200 → pwm_out continues through cnt=199 and then goes low, busy falls after cnt=255, and no sample_req is issued at that boundary.
- Async reset: assert rst_n=0 at cnt=50 while pwm_out=1 → pwm_out, busy, sample_req and overrun go to 0 immediately without waiting for a clock edge, and cnt reads 0.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared DDS definitions: controller state encoding, default widths and the
// product-to-duty quantizer used by the PWM output stage.
// Build option: define PWM_DAC_ROUND_EN to round half-up (with saturation)
// instead of truncating when reducing the product to RES bits.
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned DEF_M   = 8;
    localparam int unsigned DEF_RES = 8;

    // Working width of the quantizer; products up to QW bits are supported.
    localparam int unsigned QW = 64;

    // Reduce a pw-bit unsigned product (zero-extended to QW bits) to its top
    // res bits. The result sits in the low res bits of the return value.
    function automatic logic [QW-1:0] quantize(
        input logic [QW-1:0] mult,
        input int unsigned   pw,
        input int unsigned   res
    );
        logic [QW-1:0] top;
        logic [QW-1:0] max_val;
        top     = mult >> (pw - res);
        max_val = (QW'(1) << res) - QW'(1);
        top     = top & max_val;
`ifdef PWM_DAC_ROUND_EN
        // The bit just below the kept field decides rounding; there is none
        // when the whole product is kept.
        if (pw > res) begin
            logic [QW-1:0] below;
            below = mult >> (pw - res - 1);
            if (below[0] && (top != max_val)) begin
                top = top + QW'(1);
            end
        end
`endif
        return top;
    endfunction

endpackage

// File: rtl/pwm_dac_cnt.sv
// PWM period counter and comparator. Counts 0..2^RES-1 while running, flags
// the last count of each period, and registers the compare result as the pin.
module pwm_cnt
    import dds_pkg::*;
#(
    parameter int unsigned RES = DEF_RES
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic [RES-1:0] duty,
    output logic           wrap,
    output logic           pwm_out
);

    localparam logic [RES-1:0] CNT_MAX = '1;

    logic [RES-1:0] cnt_reg;
    logic           pwm_reg;

    // Free-running period counter while active; parked at zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= cnt_reg + RES'(1);
        end else begin
            cnt_reg <= '0;
        end
    end

    // Registered compare so the pin is glitch-free during normal operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_reg <= 1'b0;
        end else begin
            pwm_reg <= run && (cnt_reg < duty);
        end
    end

    assign wrap    = run && (cnt_reg == CNT_MAX);
    assign pwm_out = pwm_reg;

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC output stage of the DDS chain. Quantizes the amplitude product to a
// RES-bit duty, double-buffers it (pending -> duty) so the duty only changes
// on period boundaries, and paces upstream with a sample_req strobe.
// Build option: PWM_DAC_ROUND_EN selects round-half-up quantization.
module pwm_dac
    import dds_pkg::*;
#(
    parameter int unsigned M   = DEF_M,
    parameter int unsigned RES = DEF_RES
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2*M-1:0] mult,
    input  logic           mult_valid,
    input  logic           enable,
    output logic           pwm_out,
    output logic           sample_req,
    output logic           overrun,
    output logic           busy
);

    localparam int unsigned PW = 2 * M;

    state_t         state_reg;
    state_t         state_next;
    logic           load;
    logic           clr_ovr;
    logic           run;
    logic           wrap;
    logic [RES-1:0] quant_val;
    logic [RES-1:0] pending_reg;
    logic           pend_full_reg;
    logic [RES-1:0] duty_reg;
    logic           sample_req_reg;
    logic           overrun_reg;

    assign quant_val = RES'(quantize(QW'(mult), PW, RES));
    assign run       = (state_reg != IDLE);

    pwm_cnt #(
        .RES (RES)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .duty    (duty_reg),
        .wrap    (wrap),
        .pwm_out (pwm_out)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus the boundary-load and overrun-clear decisions.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        clr_ovr    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    // Entry acts as a boundary so the first period starts
                    // with a fresh duty and a clean overrun flag.
                    state_next = RUN;
                    load       = 1'b1;
                    clr_ovr    = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    if (enable) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (!enable) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    // Resumed before the period ran out: behave as RUN.
                    state_next = RUN;
                    load       = wrap;
                end else if (wrap) begin
                    // Finish the current period, then stop without loading.
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pending/duty double buffer with boundary bypass and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg    <= '0;
            pend_full_reg  <= 1'b0;
            duty_reg       <= '0;
            sample_req_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            sample_req_reg <= load;
            if (load) begin
                // A sample arriving on the boundary goes straight to duty;
                // an empty buffer leaves the previous duty in place.
                if (mult_valid) begin
                    duty_reg <= quant_val;
                end else if (pend_full_reg) begin
                    duty_reg <= pending_reg;
                end
                pend_full_reg <= 1'b0;
            end else if (mult_valid) begin
                pending_reg   <= quant_val;
                pend_full_reg <= 1'b1;
                if (pend_full_reg) begin
                    overrun_reg <= 1'b1;
                end
            end
            if (clr_ovr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    // sample_req is high in the first cycle the newly loaded duty is in effect.
    assign sample_req = sample_req_reg;
    assign overrun    = overrun_reg;
    assign busy       = run;

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac (M=8, RES=8): truncation/rounding duty, saturation,
// boundary bypass, overrun, drain and asynchronous reset.
module tb_pwm_dac;

    logic        clk;
    logic        rst_n;
    logic [15:0] mult;
    logic        mult_valid;
    logic        enable;
    logic        pwm_out;
    logic        sample_req;
    logic        overrun;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    int ph         = 0;   // bench's own notion of the period counter
    int req_seen   = 0;
    int high_seen  = 0;
    int busy_drop  = 0;

`ifdef PWM_DAC_ROUND_EN
    localparam int EXP_AA = 113;
`else
    localparam int EXP_AA = 112;
`endif

    pwm_dac #(.M(8), .RES(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mult       (mult),
        .mult_valid (mult_valid),
        .enable     (enable),
        .pwm_out    (pwm_out),
        .sample_req (sample_req),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 256;
        req_seen  += int'(sample_req);
        high_seen += int'(pwm_out);
    endtask

    task automatic wait_ph(input int target);
        for (int i = 0; i < 300 && ph != target; i++) tick();
    endtask

    task automatic measure_period();
        high_seen = 0;
        req_seen  = 0;
        repeat (256) tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        mult_valid = 1'b0;
        mult       = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req", 32'(sample_req), 0);
        check("rst_ovr", 32'(overrun), 0);

        rst_n = 1'b1;
        tick();
        tick();
        check("idle_busy", 32'(busy), 0);

        // Truncation / rounding of 0xAA*0xAA
        enable = 1'b1;
        tick();
        ph = 0;
        check("entry_req", 32'(sample_req), 1);
        check("entry_busy", 32'(busy), 1);
        mult = 16'h70E4; mult_valid = 1'b1;
        req_seen = 0;
        tick();
        mult_valid = 1'b0;
        wait_ph(255);
        check("no_req_mid", 32'(req_seen), 0);
        tick();
        check("bnd_req", 32'(sample_req), 1);
        check("bnd_pend_empty", 32'(u_dut.pend_full_reg), 0);
        measure_period();
        check("aa_highs", 32'(high_seen), 32'(EXP_AA));
        check("aa_reqs", 32'(req_seen), 1);
        check("aa_req_at_wrap", 32'(sample_req), 1);

        // Full scale product
        mult = 16'hFFFF; mult_valid = 1'b1;
        tick();
        mult_valid = 1'b0;
        wait_ph(0);
        measure_period();
        check("ffff_highs", 32'(high_seen), 255);
        check("ffff_ovr", 32'(overrun), 0);

        // Sample arriving on the boundary cycle bypasses into duty
        wait_ph(255);
        mult = 16'h8000; mult_valid = 1'b1;
        tick();
        mult_valid = 1'b0;
        check("byp_req", 32'(sample_req), 1);
        check("byp_pend", 32'(u_dut.pend_full_reg), 0);
        measure_period();
        check("byp_highs", 32'(high_seen), 128);
        check("byp_ovr", 32'(overrun), 0);
        check("byp_pend_after", 32'(u_dut.pend_full_reg), 0);

        // Two samples in one period -> overrun, last one wins
        mult = 16'h1000; mult_valid = 1'b1;
        tick();
        mult = 16'h2000;
        tick();
        mult_valid = 1'b0;
        check("ovr_set", 32'(overrun), 1);
        check("ovr_pend", 32'(u_dut.pend_full_reg), 1);
        wait_ph(0);
        measure_period();
        check("ovr_highs", 32'(high_seen), 32);
        check("ovr_sticky", 32'(overrun), 1);

        // Drain: duty 200, enable dropped at cnt=100
        mult = 16'hC800; mult_valid = 1'b1;
        tick();
        mult_valid = 1'b0;
        wait_ph(0);
        wait_ph(100);
        enable = 1'b0;
        high_seen = 0;
        req_seen  = 0;
        busy_drop = 0;
        for (int i = 0; i < 155; i++) begin
            tick();
            if (!busy) busy_drop++;
        end
        check("drain_highs", 32'(high_seen), 100);
        check("drain_busy", 32'(busy_drop), 0);
        check("drain_no_req", 32'(req_seen), 0);
        tick();
        check("drain_end_busy", 32'(busy), 0);
        check("drain_end_req", 32'(sample_req), 0);
        check("drain_end_pwm", 32'(pwm_out), 0);
        repeat (3) tick();
        check("idle_pwm", 32'(pwm_out), 0);
        check("idle_ovr_kept", 32'(overrun), 1);

        // Restart through IDLE clears overrun; empty buffer keeps duty 200
        enable = 1'b1;
        tick();
        ph = 0;
        check("restart_ovr", 32'(overrun), 0);
        check("restart_req", 32'(sample_req), 1);
        check("restart_busy", 32'(busy), 1);
        measure_period();
        check("hold_highs", 32'(high_seen), 200);

        // Asynchronous reset mid-period with the output high
        wait_ph(50);
        check("pre_rst_pwm", 32'(pwm_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pwm", 32'(pwm_out), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_req", 32'(sample_req), 0);
        check("arst_ovr", 32'(overrun), 0);
        check("arst_cnt", 32'(u_dut.u_cnt.cnt_reg), 0);
        @(posedge clk);
        #1;
        enable = 1'b0;
        rst_n  = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
